// File: rtl/i2c_defs.sv
// i2c_defs: shared definitions for the I2C EEPROM responder.
// Contents: FSM state encoding, ACK/NACK bit levels, R/W bit meanings,
// and a helper that advances a byte pointer inside its page.
package i2c_defs;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WORD,
    ST_ACK_WORD,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Increment only the in-page bits; the page (upper) bits stay put.
  function automatic logic [7:0] page_inc(input logic [7:0] ptr, input logic [7:0] mask);
    page_inc = (ptr & ~mask) | ((ptr + 8'd1) & mask);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings scl/sda into the sclk domain and detects bus events.
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   scl, sda           - raw bus pins (asynchronous)
//   scl_rise, scl_fall - one-cycle pulses on synchronized scl edges
//   start_det          - sda fell while scl high
//   stop_det           - sda rose while scl high
//   sda_s              - synchronized sda level
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;
  logic       w_scl_s;

  // Reset to the idle-bus level so leaving reset on a quiet bus is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign w_scl_s   = r_scl_sync[1];
  assign sda_s     = r_sda_sync[1];
  assign scl_rise  =  w_scl_s & ~r_scl_hist;
  assign scl_fall  = ~w_scl_s &  r_scl_hist;
  // scl must be high on both samples so an sda move during an scl edge is not a condition.
  assign start_det = w_scl_s & r_scl_hist & ~r_sda_sync[1] &  r_sda_hist;
  assign stop_det  = w_scl_s & r_scl_hist &  r_sda_sync[1] & ~r_sda_hist;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// i2c_eeprom_responder: I2C target emulating a 24C02-style 256-byte EEPROM.
// Ports:
//   sclk, rst  - system clock, synchronous active-high reset
//   scl        - I2C clock from the master (asynchronous)
//   sda        - open-drain data, driven only 0 or Z
//   busy       - high during the emulated write cycle
//   wr_strobe  - one-cycle pulse per byte committed to memory
//   rd_strobe  - one-cycle pulse per byte loaded for transmit
//   dbg_addr   - backdoor read address
//   dbg_data   - memory[dbg_addr], registered, latency 1
module i2c_eeprom_responder
  import i2c_defs::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'b1010_000,
  parameter int         PAGE_SIZE      = 8,
  parameter int         WR_BUSY_CYCLES = 250_000
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_strobe,
  output logic       rd_strobe,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);
  localparam int         BW        = $clog2(WR_BUSY_CYCLES + 1);

  logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

  i2c_line_sync u_sync (
    .clk       (sclk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det),
    .sda_s     (w_sda_s)
  );

  state_t          r_state, w_state_next;
  logic            r_sda_low, w_sda_low_next;
  logic            w_ptr_word, w_commit, w_load, w_rcv_state;
  logic [7:0]      r_shift, r_tx, r_ptr, r_mem_q, r_dbg_q;
  logic [2:0]      r_bitcnt;
  logic            r_full, r_mack, r_pending, r_busy;
  logic [BW-1:0]   r_busy_cnt;
  logic [7:0]      r_mem [0:255] = '{default: 8'hFF};

  assign w_rcv_state = (r_state == ST_ADDR) || (r_state == ST_WORD) || (r_state == ST_WR_DATA);

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sda_low <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sda_low <= w_sda_low_next;
    end
  end

  // Every drive change is tied to a synchronized scl fall, except RD_LOAD,
  // which follows the ACK fall by one cycle while scl is still low.
  always_comb begin
    w_state_next   = r_state;
    w_sda_low_next = r_sda_low;
    w_ptr_word     = 1'b0;
    w_commit       = 1'b0;
    w_load         = 1'b0;
    if (w_start_det) begin
      w_state_next   = ST_ADDR;
      w_sda_low_next = 1'b0;
    end else if (w_stop_det) begin
      w_state_next   = ST_IDLE;
      w_sda_low_next = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR: if (w_scl_fall && r_full) begin
          if (r_shift[7:1] == DEV_ADDR && !r_busy) begin
            w_state_next   = ST_ACK_ADDR;
            w_sda_low_next = 1'b1;
          end else begin
            w_state_next   = ST_IGNORE;
          end
        end
        ST_ACK_ADDR: if (w_scl_fall) begin
          w_sda_low_next = 1'b0;
          w_state_next   = (r_shift[0] == RW_READ) ? ST_RD_LOAD : ST_WORD;
        end
        ST_WORD: if (w_scl_fall && r_full) begin
          w_state_next   = ST_ACK_WORD;
          w_sda_low_next = 1'b1;
          w_ptr_word     = 1'b1;
        end
        ST_ACK_WORD: if (w_scl_fall) begin
          w_state_next   = ST_WR_DATA;
          w_sda_low_next = 1'b0;
        end
        ST_WR_DATA: if (w_scl_fall && r_full) begin
          w_state_next   = ST_ACK_WR;
          w_sda_low_next = 1'b1;
        end
        ST_ACK_WR: if (w_scl_fall) begin
          w_commit       = 1'b1;
          w_state_next   = ST_WR_DATA;
          w_sda_low_next = 1'b0;
        end
        ST_RD_LOAD: begin
          w_load         = 1'b1;
          w_state_next   = ST_RD_DATA;
          w_sda_low_next = ~r_mem_q[7];
        end
        ST_RD_DATA: if (w_scl_fall) begin
          if (r_bitcnt == 3'd7) begin
            w_state_next   = ST_RD_ACK;
            w_sda_low_next = 1'b0;
          end else begin
            w_sda_low_next = ~r_tx[6];
          end
        end
        ST_RD_ACK: if (w_scl_fall) begin
          w_state_next = (r_mack == ACK) ? ST_RD_LOAD : ST_IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_bitcnt   <= '0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_ptr      <= '0;
      r_mack     <= NACK;
      r_pending  <= 1'b0;
      r_busy     <= 1'b0;
      r_busy_cnt <= '0;
      wr_strobe  <= 1'b0;
      rd_strobe  <= 1'b0;
    end else begin
      wr_strobe <= w_commit;
      rd_strobe <= w_load;

      // The bit counter restarts on every state change, including START into ADDR.
      if (w_state_next != r_state || w_start_det) begin
        r_bitcnt <= '0;
        r_full   <= 1'b0;
      end else if (w_rcv_state && w_scl_rise && !r_full) begin
        r_shift  <= {r_shift[6:0], w_sda_s};
        r_bitcnt <= r_bitcnt + 3'd1;
        r_full   <= (r_bitcnt == 3'd7);
      end else if (r_state == ST_RD_DATA && w_scl_fall) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_tx     <= {r_tx[6:0], 1'b0};
      end

      if (w_load) r_tx <= r_mem_q;
      if (r_state == ST_RD_ACK && w_scl_rise) r_mack <= w_sda_s;

      if (w_ptr_word)    r_ptr <= r_shift;
      else if (w_commit) r_ptr <= page_inc(r_ptr, PAGE_MASK);
      else if (w_load)   r_ptr <= r_ptr + 8'd1;

      if (w_stop_det && r_pending) begin
        r_busy     <= 1'b1;
        r_busy_cnt <= BW'(WR_BUSY_CYCLES);
        r_pending  <= 1'b0;
      end else begin
        if (r_busy) begin
          r_busy_cnt <= r_busy_cnt - BW'(1);
          if (r_busy_cnt == BW'(1)) r_busy <= 1'b0;
        end
        if (w_commit) r_pending <= 1'b1;
      end
    end
  end

  // r_mem_q tracks mem[ptr] continuously so RD_LOAD needs no extra wait.
  always_ff @(posedge sclk) begin
    if (w_commit && !rst) r_mem[r_ptr] <= r_shift;
    r_mem_q <= r_mem[r_ptr];
    r_dbg_q <= r_mem[dbg_addr];
  end

  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign busy     = r_busy;
  assign dbg_data = r_dbg_q;

endmodule

// File: doc/i2c_eeprom_responder.md
Name: i2c_eeprom_responder

Overview:
- I2C target (responder) that emulates a 24C02-style 256-byte EEPROM.
- It is the far end of the I2C master used by the 3-byte EEPROM read/write path.
- Used in simulation benches, and on-board as a loopback target on spare pins, so the master can be verified without a physical EEPROM.
- Supports byte write, page write with in-page wrap, current-address read, random read, sequential read, and ACK polling during an emulated write cycle.

Parameters:
- DEV_ADDR, 7'b1010_000, unshifted 7-bit device address.
- PAGE_SIZE, 8, page-write boundary in bytes; power of 2.
- WR_BUSY_CYCLES, 250_000, sclk cycles the device NACKs its address after a write STOP (5 ms at 50 MHz).

Ports:
- sclk, in, 1, system clock 50 MHz.
- rst, in, 1, synchronous active-high reset.
- scl, in, 1, I2C clock from master; asynchronous to sclk.
- sda, inout, 1, open-drain data; block drives only 0 or Z.
- busy, out, 1, high during emulated write cycle.
- wr_strobe, out, 1, one-cycle pulse per byte committed to memory.
- rd_strobe, out, 1, one-cycle pulse per byte loaded for transmit.
- dbg_addr, in, 8, backdoor read address.
- dbg_data, out, 8, memory[dbg_addr], registered, latency 1.

Behaviour:
- Sync: scl and sda each pass a 2-FF synchronizer plus a history FF. Edges are detected on the synchronized signals; all actions occur 3 sclk after the pin event. Glitches shorter than 1 sclk are not filtered.
- START: sda falls while scl is high. STOP: sda rises while scl is high. Both are detected in any state. START aborts the current transfer and enters ADDR (repeated start). STOP enters IDLE.
- Bits are sampled on the synchronized scl rising edge, MSB first, using a 3-bit counter plus an 8-bit shift register.
- Drive changes happen only on the synchronized scl falling edge. Drive is released (Z) on the falling edge that ends the ACK or data bit.
- FSM states and transitions:
  - IDLE: waits for START.
  - ADDR: receives 8 bits. If addr[7:1]==DEV_ADDR and !busy, go to ACK_ADDR. Otherwise go to IGNORE (release sda until next START/STOP).
  - ACK_ADDR: drive 0 for one scl period. If R/W=0 go to WORD; if R/W=1 go to RD_LOAD.
  - WORD: receive 8 bits into ptr, then ACK_WORD, then WR_DATA.
  - WR_DATA: receive byte, then ACK_WR.
    - Commit at the ACK falling edge: mem[ptr] <= byte, wr_strobe pulses.
    - ptr low bits increment modulo PAGE_SIZE; high bits are unchanged (page wrap).
    - Return to WR_DATA. Set the write_pending flag.
  - RD_LOAD: tx <= mem[ptr], rd_strobe pulses, ptr increments modulo 256. Go to RD_DATA.
  - RD_DATA: drive tx MSB first (bit value 1 = Z). After 8 bits go to RD_ACK.
  - RD_ACK: sample master's bit on scl rising edge. ACK (0) goes to RD_LOAD; NACK (1) goes to IGNORE.
- STOP with write_pending: load busy counter with WR_BUSY_CYCLES, busy=1, clear write_pending. Address ACKs are withheld until the counter reaches 0.
- START+address+STOP with no data byte: no busy, memory unchanged, ptr keeps the loaded word address.
- ptr persists across transfers. This makes current-address read continue from last access+1.
- Reset values: state IDLE, sda released, busy 0, ptr 0, strobes 0, write_pending 0, busy counter 0.
- Memory contents are not reset; initialize to 8'hFF at configuration/sim start.
- Reset mid-transfer releases sda in the same cycle that rst is sampled. A byte whose ACK has not yet completed is not committed.

Decomposition:
- Shared package/header i2c_defs: FSM state encodings, ACK=0/NACK=1, RW_WRITE/RW_READ constants.
- Sub-module i2c_line_sync: synchronizer, edge detection, and START/STOP detection for scl/sda. Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
- Memory is an inferred 256x8 array in the top level.

Test Plan:
- Page write, then random read. Write: addr 0xA0, word 10, data 23/56/39, STOP. Random read: wait busy=0, then 0xA0, word 10, Sr, 0xA1, read 3 with ACK,ACK,NACK. Expect:
  - 3 wr_strobe pulses.
  - busy for WR_BUSY_CYCLES.
  - Read returns 23,56,39.
  - dbg_addr=11 gives 56.
- ACK polling: immediately after the write STOP, send 0xA0. Expect NACK while busy=1 and ACK on the first attempt after busy falls.
- Page wrap: write 5 bytes 1..5 at word 0x06 with PAGE_SIZE=8. Expect mem[6]=1, mem[7]=2, mem[0]=3, mem[1]=4, mem[2]=5; mem[8] stays 0xFF.
- Address mismatch: send 0xA2 followed by data bytes. Expect sda never driven low, no strobes, and memory unchanged.
- Sequential read wrap: random read from 0xFE for 4 bytes. Expect mem[FE], mem[FF], mem[00], mem[01]. A following current-address read returns mem[02].
- Reset mid-read: assert rst during RD_DATA bit 3. Expect sda=Z the next cycle and state IDLE. A subsequent full transaction is ACKed.
